// File: rtl/nv_nvdla_cmac_reg_pkg.sv
// rtl/nv_nvdla_cmac_reg_pkg.sv - CMAC register controller shared constants and types
// Purpose: register offsets, field positions, reset values and the per-group
//          D_ config record shared by the CMAC register controller files.
// Ports:   none (package).
package nv_nvdla_cmac_reg_pkg;

  // Register byte offsets
  localparam logic [11:0] S_STATUS    = 12'h000;
  localparam logic [11:0] S_POINTER   = 12'h004;
  localparam logic [11:0] D_OP_ENABLE = 12'h008;
  localparam logic [11:0] D_MISC_CFG  = 12'h00c;

  // Field bit positions
  localparam int OP_EN_BIT     = 0;
  localparam int CONV_MODE_BIT = 0;
  localparam int PREC_LSB      = 12;
  localparam int PROD_PTR_LSB  = 0;
  localparam int CONS_PTR_LSB  = 16;

  localparam logic [1:0] PREC_RESET = 2'b01;

  typedef struct packed {
    logic       conv_mode;
    logic [1:0] proc_precision;
  } cmac_dcfg_t;

  localparam cmac_dcfg_t DCFG_RESET = '{conv_mode: 1'b0, proc_precision: PREC_RESET};

endpackage

// File: rtl/nv_nvdla_cmac_reg_group.sv
// rtl/nv_nvdla_cmac_reg_group.sv - one shadow copy of the CMAC D_ register group
// Purpose: holds one group's config record and its op_en flag.
// Ports:   nvdla_core_clk/nvdla_core_rst  clock, sync active-high reset
//          cfg_wr, cfg_wr_data            load the config record
//          op_en_set, op_en_clr           set / clear op_en
//          cfg, op_en                     current contents
module nv_nvdla_cmac_reg_group
  import nv_nvdla_cmac_reg_pkg::*;
(
  input  logic       nvdla_core_clk,
  input  logic       nvdla_core_rst,
  input  logic       cfg_wr,
  input  cmac_dcfg_t cfg_wr_data,
  input  logic       op_en_set,
  input  logic       op_en_clr,
  output cmac_dcfg_t cfg,
  output logic       op_en
);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cfg   <= DCFG_RESET;
      op_en <= 1'b0;
    end else begin
      if (cfg_wr) begin
        cfg <= cfg_wr_data;
      end
      // Set needs the group unlocked and clear needs it running, so they
      // cannot coincide; clear wins regardless.
      if (op_en_clr) begin
        op_en <= 1'b0;
      end else if (op_en_set) begin
        op_en <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cmac_reg_ctrl.sv
// rtl/nv_nvdla_cmac_reg_ctrl.sv - CMAC register controller with shadowed D_ groups
// Purpose: software programs the producer group while the datapath runs the
//          consumer group; dp_done retires the consumer group and raises done_intr.
// Ports:   nvdla_core_clk/nvdla_core_rst       clock, sync active-high reset
//          reg_offset/reg_wr_data/reg_wr_en    register write port
//          reg_rd_data                         combinational read data
//          dp_done                             consumer group finished
//          dp_op_en/dp_conv_mode/dp_proc_precision/dp_group  consumer group view
//          op_en_trigger                       accepted op_enable write
//          done_intr/done_intr_group           registered completion pulse
module nv_nvdla_cmac_reg_ctrl
  import nv_nvdla_cmac_reg_pkg::*;
#(
  parameter int NUM_GROUPS = 2,
  parameter int PTR_W      = $clog2(NUM_GROUPS)
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic [11:0]      reg_offset,
  input  logic [31:0]      reg_wr_data,
  input  logic             reg_wr_en,
  output logic [31:0]      reg_rd_data,
  input  logic             dp_done,
  output logic             dp_op_en,
  output logic             dp_conv_mode,
  output logic [1:0]       dp_proc_precision,
  output logic [PTR_W-1:0] dp_group,
  output logic             op_en_trigger,
  output logic             done_intr,
  output logic [PTR_W-1:0] done_intr_group
);

  logic [PTR_W-1:0]      prod_ptr;
  logic [PTR_W-1:0]      cons_ptr;
  logic [NUM_GROUPS-1:0] op_en_vec;
  cmac_dcfg_t            cfg_arr [NUM_GROUPS];

  logic       prod_locked;
  logic       cfg_acc;
  logic       op_en_acc;
  logic       ptr_wr;
  logic       done_acc;
  cmac_dcfg_t cfg_wr_data;
  logic       unused_wr_data;

  // Lock is taken from pre-edge state, so a write racing a dp_done on the
  // same group is still dropped.
  assign prod_locked = op_en_vec[prod_ptr];
  assign cfg_acc     = reg_wr_en && (reg_offset == D_MISC_CFG) && !prod_locked;
  assign op_en_acc   = reg_wr_en && (reg_offset == D_OP_ENABLE) && !prod_locked
                       && reg_wr_data[OP_EN_BIT];
  assign ptr_wr      = reg_wr_en && (reg_offset == S_POINTER);
  assign done_acc    = dp_done && op_en_vec[cons_ptr];

  assign cfg_wr_data = '{conv_mode:      reg_wr_data[CONV_MODE_BIT],
                         proc_precision: reg_wr_data[PREC_LSB +: 2]};
  assign unused_wr_data = ^reg_wr_data;

  assign op_en_trigger = op_en_acc;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    nv_nvdla_cmac_reg_group u_grp (
      .nvdla_core_clk (nvdla_core_clk),
      .nvdla_core_rst (nvdla_core_rst),
      .cfg_wr         (cfg_acc && (prod_ptr == PTR_W'(g))),
      .cfg_wr_data    (cfg_wr_data),
      .op_en_set      (op_en_acc && (prod_ptr == PTR_W'(g))),
      .op_en_clr      (done_acc && (cons_ptr == PTR_W'(g))),
      .cfg            (cfg_arr[g]),
      .op_en          (op_en_vec[g])
    );
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      prod_ptr        <= '0;
      cons_ptr        <= '0;
      done_intr       <= 1'b0;
      done_intr_group <= '0;
    end else begin
      if (ptr_wr) begin
        prod_ptr <= reg_wr_data[PROD_PTR_LSB +: PTR_W];
      end
      // NUM_GROUPS is a power of two, so natural overflow is the modulo wrap.
      if (done_acc) begin
        cons_ptr        <= cons_ptr + PTR_W'(1);
        done_intr_group <= cons_ptr;
      end
      done_intr <= done_acc;
    end
  end

  assign dp_op_en          = op_en_vec[cons_ptr];
  assign dp_conv_mode      = cfg_arr[cons_ptr].conv_mode;
  assign dp_proc_precision = cfg_arr[cons_ptr].proc_precision;
  assign dp_group          = cons_ptr;

  always_comb begin
    reg_rd_data = '0;
    case (reg_offset)
      S_STATUS: begin
        reg_rd_data[NUM_GROUPS-1:0] = op_en_vec;
      end
      S_POINTER: begin
        reg_rd_data[PROD_PTR_LSB +: PTR_W] = prod_ptr;
        reg_rd_data[CONS_PTR_LSB +: PTR_W] = cons_ptr;
      end
      D_OP_ENABLE: begin
        reg_rd_data[OP_EN_BIT] = op_en_vec[prod_ptr];
      end
      D_MISC_CFG: begin
        reg_rd_data[CONV_MODE_BIT]     = cfg_arr[prod_ptr].conv_mode;
        reg_rd_data[PREC_LSB +: 2]     = cfg_arr[prod_ptr].proc_precision;
      end
      default: begin
        reg_rd_data = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_nv_nvdla_cmac_reg_ctrl.sv
// tb/tb_nv_nvdla_cmac_reg_ctrl.sv - self-checking bench for nv_nvdla_cmac_reg_ctrl
module tb_nv_nvdla_cmac_reg_ctrl;

  logic        clk;
  logic        rst;

  // two-group instance
  logic [11:0] reg_offset;
  logic [31:0] reg_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_rd_data;
  logic        dp_done;
  logic        dp_op_en;
  logic        dp_conv_mode;
  logic [1:0]  dp_proc_precision;
  logic [0:0]  dp_group;
  logic        op_en_trigger;
  logic        done_intr;
  logic [0:0]  done_intr_group;

  // four-group instance
  logic [11:0] reg_offset4;
  logic [31:0] reg_wr_data4;
  logic        reg_wr_en4;
  logic [31:0] reg_rd_data4;
  logic        dp_done4;
  logic        dp_op_en4;
  logic        dp_conv_mode4;
  logic [1:0]  dp_proc_precision4;
  logic [1:0]  dp_group4;
  logic        op_en_trigger4;
  logic        done_intr4;
  logic [1:0]  done_intr_group4;

  int total = 0;
  int bad   = 0;
  int trig_cnt = 0;
  logic last_trig;
  int exp_q [$];

  nv_nvdla_cmac_reg_ctrl #(.NUM_GROUPS(2)) u_dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .reg_offset        (reg_offset),
    .reg_wr_data       (reg_wr_data),
    .reg_wr_en         (reg_wr_en),
    .reg_rd_data       (reg_rd_data),
    .dp_done           (dp_done),
    .dp_op_en          (dp_op_en),
    .dp_conv_mode      (dp_conv_mode),
    .dp_proc_precision (dp_proc_precision),
    .dp_group          (dp_group),
    .op_en_trigger     (op_en_trigger),
    .done_intr         (done_intr),
    .done_intr_group   (done_intr_group)
  );

  nv_nvdla_cmac_reg_ctrl #(.NUM_GROUPS(4)) u_dut4 (
    .nvdla_core_clk    (clk),
    .nvdla_core_rst    (rst),
    .reg_offset        (reg_offset4),
    .reg_wr_data       (reg_wr_data4),
    .reg_wr_en         (reg_wr_en4),
    .reg_rd_data       (reg_rd_data4),
    .dp_done           (dp_done4),
    .dp_op_en          (dp_op_en4),
    .dp_conv_mode      (dp_conv_mode4),
    .dp_proc_precision (dp_proc_precision4),
    .dp_group          (dp_group4),
    .op_en_trigger     (op_en_trigger4),
    .done_intr         (done_intr4),
    .done_intr_group   (done_intr_group4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every done_intr cycle must match a queued expectation.
  always @(negedge clk) begin
    if (op_en_trigger) trig_cnt++;
    if (done_intr) begin
      if (exp_q.size() == 0) chk("intr_unexpected", 32'(done_intr), 32'd0);
      else chk("intr_group", 32'(done_intr_group), 32'(exp_q.pop_front()));
    end
  end

  // Called at posedge+1; leaves at posedge+1 after the write edge.
  task automatic wr(input logic [11:0] off, input logic [31:0] d, input logic done);
    reg_offset  = off;
    reg_wr_data = d;
    reg_wr_en   = 1'b1;
    dp_done     = done;
    @(negedge clk);
    last_trig = op_en_trigger;
    @(posedge clk); #1;
    reg_wr_en = 1'b0;
    dp_done   = 1'b0;
  endtask

  task automatic pulse_done();
    dp_done = 1'b1;
    @(posedge clk); #1;
    dp_done = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] off, input logic [31:0] exp);
    reg_offset = off;
    #1;
    chk(tag, reg_rd_data, exp);
  endtask

  task automatic wr4(input logic [11:0] off, input logic [31:0] d);
    reg_offset4  = off;
    reg_wr_data4 = d;
    reg_wr_en4   = 1'b1;
    @(posedge clk); #1;
    reg_wr_en4 = 1'b0;
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    reg_offset = '0; reg_wr_data = '0; reg_wr_en = 1'b0; dp_done = 1'b0;
    reg_offset4 = '0; reg_wr_data4 = '0; reg_wr_en4 = 1'b0; dp_done4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    rd_chk("rst_misc", 12'h00c, 32'h0000_1000);
    rd_chk("rst_status", 12'h000, 32'h0);
    rd_chk("rst_pointer", 12'h004, 32'h0);
    rd_chk("rst_unmapped", 12'h010, 32'h0);
    chk("rst_dp_op_en", 32'(dp_op_en), 32'd0);
    chk("rst_done_intr", 32'(done_intr), 32'd0);

    // Program and enable group 0
    wr(12'h00c, 32'h0000_2001, 1'b0);
    chk("misc_wr_no_trig", 32'(last_trig), 32'd0);
    t0 = trig_cnt;
    wr(12'h008, 32'h1, 1'b0);
    chk("open_trig", 32'(last_trig), 32'd1);
    chk("open_trig_once", 32'(trig_cnt - t0), 32'd1);
    chk("open_trig_low_after", 32'(op_en_trigger), 32'd0);
    rd_chk("status_g0", 12'h000, 32'h1);
    chk("dp_op_en_g0", 32'(dp_op_en), 32'd1);
    chk("dp_conv_g0", 32'(dp_conv_mode), 32'd1);
    chk("dp_prec_g0", 32'(dp_proc_precision), 32'd2);

    // Locked producer group drops writes
    wr(12'h00c, 32'h0, 1'b0);
    rd_chk("locked_misc", 12'h00c, 32'h0000_2001);
    wr(12'h008, 32'h1, 1'b0);
    chk("locked_open_no_trig", 32'(last_trig), 32'd0);

    // Program group 1 while group 0 runs
    wr(12'h004, 32'h1, 1'b0);
    wr(12'h00c, 32'h0000_0001, 1'b0);
    rd_chk("g1_misc", 12'h00c, 32'h0000_0001);
    rd_chk("g1_pointer", 12'h004, 32'h0000_0001);
    rd_chk("g1_opreg", 12'h008, 32'h0);
    chk("dp_conv_unchanged", 32'(dp_conv_mode), 32'd1);
    chk("dp_prec_unchanged", 32'(dp_proc_precision), 32'd2);

    // Retire group 0
    exp_q.push_back(0);
    pulse_done();
    chk("done_intr_high", 32'(done_intr), 32'd1);
    rd_chk("ptr_after_done", 12'h004, 32'h0001_0001);
    rd_chk("status_after_done", 12'h000, 32'h0);
    chk("dp_group_after_done", 32'(dp_group), 32'd1);

    // dp_done while consumer idle is ignored
    @(posedge clk); #1;
    pulse_done();
    rd_chk("ptr_ignored_done", 12'h004, 32'h0001_0001);

    // Enable and retire group 1, wrap consumer back to 0
    wr(12'h008, 32'h1, 1'b0);
    chk("g1_trig", 32'(last_trig), 32'd1);
    chk("dp_conv_g1", 32'(dp_conv_mode), 32'd1);
    chk("dp_prec_g1", 32'(dp_proc_precision), 32'd0);
    exp_q.push_back(1);
    pulse_done();
    rd_chk("ptr_wrap2", 12'h004, 32'h0000_0001);

    // Enable group 0, then done + op_enable on the same group together
    wr(12'h004, 32'h0, 1'b0);
    wr(12'h008, 32'h1, 1'b0);
    exp_q.push_back(0);
    wr(12'h008, 32'h1, 1'b1);
    chk("same_grp_no_trig", 32'(last_trig), 32'd0);
    rd_chk("same_grp_status", 12'h000, 32'h0);
    rd_chk("same_grp_ptr", 12'h004, 32'h0001_0000);

    // Done on group 1 together with op_enable on group 0: both apply
    wr(12'h004, 32'h1, 1'b0);
    wr(12'h008, 32'h1, 1'b0);
    wr(12'h004, 32'h0, 1'b0);
    exp_q.push_back(1);
    wr(12'h008, 32'h1, 1'b1);
    chk("diff_grp_trig", 32'(last_trig), 32'd1);
    rd_chk("diff_grp_status", 12'h000, 32'h1);
    rd_chk("diff_grp_ptr", 12'h004, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset on the edge a dp_done is accepted
    chk("pre_rst_dp_op_en", 32'(dp_op_en), 32'd1);
    wr(12'h004, 32'h1, 1'b0);
    rst = 1'b1;
    dp_done = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dp_done = 1'b0;
    chk("rst_mid_intr", 32'(done_intr), 32'd0);
    chk("rst_mid_intr_grp", 32'(done_intr_group), 32'd0);
    chk("rst_mid_dp_op_en", 32'(dp_op_en), 32'd0);
    rd_chk("rst_mid_status", 12'h000, 32'h0);
    rd_chk("rst_mid_ptr", 12'h004, 32'h0);
    rd_chk("rst_mid_misc0", 12'h00c, 32'h0000_1000);
    wr(12'h004, 32'h1, 1'b0);
    rd_chk("rst_mid_misc1", 12'h00c, 32'h0000_1000);
    @(posedge clk); #1;

    // Four-group instance: enable all, retire all, consumer wraps 3 -> 0
    for (int k = 0; k < 4; k++) begin
      wr4(12'h004, 32'(k));
      wr4(12'h008, 32'h1);
    end
    reg_offset4 = 12'h000;
    #1;
    chk("g4_status_all", reg_rd_data4, 32'hF);
    for (int k = 0; k < 4; k++) begin
      dp_done4 = 1'b1;
      @(posedge clk); #1;
      dp_done4 = 1'b0;
      chk("g4_intr", 32'(done_intr4), 32'd1);
      chk("g4_intr_grp", 32'(done_intr_group4), 32'(k));
      chk("g4_dp_group", 32'(dp_group4), 32'((k + 1) % 4));
    end
    reg_offset4 = 12'h004;
    #1;
    chk("g4_ptr_wrap", reg_rd_data4, 32'h0000_0003);
    chk("g4_dp_op_en", 32'(dp_op_en4), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_cmac_reg_ctrl.md
# nv_nvdla_cmac_reg_ctrl

Parametrised CMAC register controller with NUM_GROUPS shadow copies of the D_ register group, producer/consumer pointers, and internally held per-group op_en state. Software programs the group selected by the producer pointer while the datapath runs the group selected by the consumer pointer. The block sits between the CSB register adapter and the CMAC datapath. It replaces the single-group register file, whose op_en had to be held by external logic.

## Interface
- NUM_GROUPS, 2, number of shadow D_ groups; must be a power of two, 2..4.
- PTR_W, $clog2(NUM_GROUPS), pointer width; derived, do not override.
- nvdla_core_clk  in  1  the block's only clock.
- nvdla_core_rst  in  1  reset, synchronous, active-high; all state is reset on the clock edge where it is high.
- reg_offset  in  12  register byte offset.
- reg_wr_data  in  32  write data.
- reg_wr_en  in  1  one-cycle write strobe.
- reg_rd_data  out  32  read data; combinational from reg_offset and current state.
- dp_done  in  1  one-cycle pulse from the datapath: the consumer group has finished.
- dp_op_en  out  1  op_en of the consumer group.
- dp_conv_mode  out  1  conv_mode of the consumer group.
- dp_proc_precision  out  2  proc_precision of the consumer group.
- dp_group  out  PTR_W  consumer pointer.
- op_en_trigger  out  1  pulse on an accepted op_enable write.
- done_intr  out  1  registered pulse, one cycle after an accepted dp_done.
- done_intr_group  out  PTR_W  group that finished; valid while done_intr is high.

## Operation
- Register map (byte offsets):
  - 0x000 S_STATUS (RO): bit g = op_en[g].
  - 0x004 S_POINTER: bits[PTR_W-1:0] = producer pointer (RW); bits[16+PTR_W-1:16] = consumer pointer (RO).
  - 0x008 D_OP_ENABLE: bit0 = op_en of the producer group.
  - 0x00c D_MISC_CFG: bit0 = conv_mode, bits[13:12] = proc_precision, for the producer group.
  - Any other offset reads 0; writes to it are ignored.
- Producer group locking: while op_en of the producer group is 1, writes to D_MISC_CFG and D_OP_ENABLE are dropped. Reads of those registers still return the producer group's contents.
- op_enable write:
  - Accepted only if bit0 = 1 and the producer group is unlocked.
  - On accept, op_en[prod] is set and op_en_trigger = 1 in the same cycle.
  - Writing bit0 = 0 never clears op_en.
- dp_done is accepted only when dp_op_en = 1; it is ignored otherwise. On accept:
  - op_en[cons] clears;
  - the consumer pointer increments modulo NUM_GROUPS;
  - done_intr pulses on the next cycle, with done_intr_group = the old consumer pointer.
- The producer pointer changes only by software write; the written value is masked to PTR_W bits. The hardware does not auto-advance it.
- Reset values: conv_mode = 0 and proc_precision = 2'b01 in every group; all op_en = 0; both pointers = 0; done_intr = 0; done_intr_group = 0.

## Timing
- Config registers and op_en update on the clock edge after the write cycle. The dp_* outputs reflect the change in the cycle after that edge.
- op_en_trigger is combinational from reg_wr_en: a single cycle, coincident with the write.
- dp_done and a write to the same group in the same cycle:
  - The lock is evaluated on state before the edge, so the write is dropped.
  - The done is applied.
- dp_done and an accepted op_enable write to a different group in the same cycle: both take effect.
- Reset asserted mid-operation: every state element returns to its reset value on that edge. A done_intr that was due on that edge is suppressed.

## Structure
- The shared package nv_nvdla_cmac_reg_pkg holds:
  - the offset constants (S_STATUS, S_POINTER, D_OP_ENABLE, D_MISC_CFG);
  - the field bit positions;
  - PREC_RESET = 2'b01;
  - a packed typedef cmac_dcfg_t {conv_mode, proc_precision}.
- One sub-module, nv_nvdla_cmac_reg_group, instantiated NUM_GROUPS times. Each instance holds one cmac_dcfg_t plus op_en, with write, set and clear controls. The pointer logic, the read mux and done_intr stay in the top level.

## Test plan
- Reset with NUM_GROUPS = 2: read 0x00c -> 0x00001000, 0x000 -> 0, 0x004 -> 0; dp_op_en = 0.
- Write 0x00c = 0x00002001, then 0x008 = 1 -> op_en_trigger pulses once; S_STATUS = 0x1; dp_conv_mode = 1; dp_proc_precision = 2'b10.
- With group 0 active, write 0x00c = 0 -> dropped, reads back 0x00002001. Then write 0x004 = 1 and 0x00c = 0x00000001 -> group 1 is programmed, dp_* are unchanged.
- Pulse dp_done -> next cycle done_intr = 1 with done_intr_group = 0; S_POINTER = 0x00010001; S_STATUS = 0. dp_done again with dp_op_en = 0 -> no effect.
- In the same cycle, dp_done (consumer 0) and a write 0x008 = 1 to producer group 0 -> the write is dropped, op_en[0] = 0, no op_en_trigger. Also cover pointer wrap from 3 to 0 with NUM_GROUPS = 4.
- Assert nvdla_core_rst in the cycle dp_done is accepted -> done_intr stays 0; all reset values restored.
